// File: rtl/if_stage_if.sv
// Fetch-stage port bundle: decode handshake, branch feedback and instruction SRAM.
// master = fetch stage, slave = decode/SRAM side.
interface if_stage_if #(
  parameter int XLEN = 32
);
  logic              ds_allowin;
  logic [XLEN:0]     br_bus;
  logic              fs_to_ds_valid;
  logic [2*XLEN-1:0] fs_to_ds_bus;
  logic              inst_sram_en;
  logic [3:0]        inst_sram_we;
  logic [XLEN-1:0]   inst_sram_addr;
  logic [XLEN-1:0]   inst_sram_wdata;
  logic [XLEN-1:0]   inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS fetch stage: pre-IF next-PC generation, 1-cycle SRAM fetch, stall buffer
// and delay-slot-aware branch redirection.
module if_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus
);
  localparam logic [XLEN-1:0] PC_INIT = RESET_PC - XLEN'(4);

  logic            preif_valid_q, preif_valid_d;
  logic            fs_valid_q, fs_valid_d;
  logic [XLEN-1:0] fs_pc_q, fs_pc_d;
  logic            data_fresh_q, data_fresh_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;
  logic            br_pend_q, br_pend_d;
  logic [XLEN-1:0] br_pend_target_q, br_pend_target_d;

  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            fs_ready_go;
  logic            fs_allowin;
  logic            fs_to_ds_valid;
  logic            inst_sram_en;
  logic [XLEN-1:0] nextpc;
  logic [XLEN-1:0] fs_inst;

  assign br_taken  = bus.br_bus[XLEN];
  assign br_target = bus.br_bus[XLEN-1:0];

  always_comb begin
    fs_ready_go    = 1'b1;
    fs_allowin     = ~fs_valid_q | (fs_ready_go & bus.ds_allowin);
    fs_to_ds_valid = fs_valid_q & fs_ready_go;
    inst_sram_en   = preif_valid_q & fs_allowin;

    // With fs empty the delay slot has not been fetched yet, so fall through.
    if (br_taken && fs_valid_q)       nextpc = br_target;
    else if (br_pend_q && fs_valid_q) nextpc = br_pend_target_q;
    else                              nextpc = fs_pc_q + XLEN'(4);

    fs_inst = buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;
  end

  always_comb begin
    preif_valid_d    = 1'b1;
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    data_fresh_d     = 1'b0;
    buf_valid_d      = buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;

    if (inst_sram_en) begin
      fs_valid_d   = 1'b1;
      fs_pc_d      = nextpc;
      data_fresh_d = 1'b1;
      buf_valid_d  = 1'b0;
    end else if (fs_to_ds_valid && bus.ds_allowin) begin
      fs_valid_d = 1'b0;
    end

    // SRAM rdata is only trustworthy in its fresh cycle; keep a copy on stall.
    if (data_fresh_q && fs_valid_q && !bus.ds_allowin) begin
      inst_buf_d  = bus.inst_sram_rdata;
      buf_valid_d = 1'b1;
    end

    if (inst_sram_en && fs_valid_q && (br_taken || br_pend_q))
      br_pend_d = 1'b0;
    if (br_taken && (!fs_valid_q || !inst_sram_en)) begin
      br_pend_d        = 1'b1;
      br_pend_target_d = br_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preif_valid_q    <= 1'b0;
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= PC_INIT;
      data_fresh_q     <= 1'b0;
      buf_valid_q      <= 1'b0;
      inst_buf_q       <= '0;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= '0;
    end else begin
      preif_valid_q    <= preif_valid_d;
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      data_fresh_q     <= data_fresh_d;
      buf_valid_q      <= buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
    end
  end

  assign bus.fs_to_ds_valid  = fs_to_ds_valid;
  assign bus.fs_to_ds_bus    = {fs_pc_q, fs_inst};
  assign bus.inst_sram_en    = inst_sram_en;
  assign bus.inst_sram_we    = 4'b0000;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = '0;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: synchronous SRAM model returning addr^0x5A5A5A5A,
// and 0xDEADBEEF on any cycle without a read so stale data is visible.
module tb_if_stage;
  localparam logic [31:0] K = 32'h5A5A5A5A;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  if_stage_if #(.XLEN(32)) bus ();

  if_stage #(.XLEN(32), .RESET_PC(32'hBFC00000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr ^ K;
    else                  bus.inst_sram_rdata <= 32'hDEADBEEF;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic en, input logic [31:0] addr);
    check_eq({tag, " en"}, 64'(bus.inst_sram_en), 64'(en));
    if (en) check_eq({tag, " addr"}, 64'(bus.inst_sram_addr), 64'(addr));
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    check_eq({tag, " valid"}, 64'(bus.fs_to_ds_valid), 64'(v));
    if (v) check_eq({tag, " bus"}, bus.fs_to_ds_bus, {pc, inst});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.ds_allowin = 1'b1;
    bus.br_bus = '0;
    bus.inst_sram_rdata = '0;

    tick(); tick();
    #1;
    expect_req("in_reset", 1'b0, 32'h0);
    expect_out("in_reset", 1'b0, 32'h0, 32'h0);
    check_eq("in_reset we", 64'(bus.inst_sram_we), 64'h0);

    // release and sequential stream
    tick(); reset = 1'b1; #1;
    expect_req("c0", 1'b0, 32'h0);
    expect_out("c0", 1'b0, 32'h0, 32'h0);
    tick(); #1;
    expect_req("c1", 1'b1, 32'hBFC00000);
    expect_out("c1", 1'b0, 32'h0, 32'h0);
    tick(); #1;
    expect_out("c2", 1'b1, 32'hBFC00000, 32'hBFC00000 ^ K);
    expect_req("c2", 1'b1, 32'hBFC00004);
    tick(); #1;
    expect_out("c3", 1'b1, 32'hBFC00004, 32'hBFC00004 ^ K);

    // decode stall while fs holds ...08
    tick(); bus.ds_allowin = 1'b0; #1;
    expect_out("stall0", 1'b1, 32'hBFC00008, 32'hBFC00008 ^ K);
    expect_req("stall0", 1'b0, 32'h0);
    tick(); #1;
    expect_out("stall1", 1'b1, 32'hBFC00008, 32'hBFC00008 ^ K);
    expect_req("stall1", 1'b0, 32'h0);
    tick(); #1;
    expect_out("stall2", 1'b1, 32'hBFC00008, 32'hBFC00008 ^ K);
    tick(); bus.ds_allowin = 1'b1; #1;
    expect_out("unstall", 1'b1, 32'hBFC00008, 32'hBFC00008 ^ K);
    expect_req("unstall", 1'b1, 32'hBFC0000C);
    tick(); #1;
    expect_out("c8", 1'b1, 32'hBFC0000C, 32'hBFC0000C ^ K);

    // taken branch with delay slot ...10 in fs
    tick(); bus.br_bus = {1'b1, 32'hBFC00100}; #1;
    expect_out("dslot", 1'b1, 32'hBFC00010, 32'hBFC00010 ^ K);
    expect_req("br", 1'b1, 32'hBFC00100);
    tick(); bus.br_bus = '0; #1;
    expect_out("tgt", 1'b1, 32'hBFC00100, 32'hBFC00100 ^ K);
    expect_req("tgt", 1'b1, 32'hBFC00104);

    // branch while decode stalled (delay slot ...104 held)
    tick(); bus.ds_allowin = 1'b0; bus.br_bus = {1'b1, 32'hBFC00200}; #1;
    expect_out("brst0", 1'b1, 32'hBFC00104, 32'hBFC00104 ^ K);
    expect_req("brst0", 1'b0, 32'h0);
    tick(); bus.br_bus = '0; #1;
    expect_out("brst1", 1'b1, 32'hBFC00104, 32'hBFC00104 ^ K);
    tick(); bus.ds_allowin = 1'b1; #1;
    expect_req("pend", 1'b1, 32'hBFC00200);
    tick(); #1;
    expect_out("pendtgt", 1'b1, 32'hBFC00200, 32'hBFC00200 ^ K);
    expect_req("pendclr", 1'b1, 32'hBFC00204);

    // reset in the cycle after a request
    tick(); reset = 1'b0; #1;
    expect_out("rst_mid", 1'b0, 32'h0, 32'h0);
    expect_req("rst_mid", 1'b0, 32'h0);
    tick(); tick(); reset = 1'b1; #1;
    expect_out("rs0", 1'b0, 32'h0, 32'h0);
    tick(); #1;
    expect_out("rs1", 1'b0, 32'h0, 32'h0);
    expect_req("rs1", 1'b1, 32'hBFC00000);
    tick(); bus.br_bus = {1'b1, 32'hFFFFFFFC}; #1;
    expect_out("rs2", 1'b1, 32'hBFC00000, 32'hBFC00000 ^ K);
    expect_req("brwrap", 1'b1, 32'hFFFFFFFC);
    tick(); bus.br_bus = '0; #1;
    expect_out("top", 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC ^ K);
    expect_req("wrap", 1'b1, 32'h00000000);
    tick(); #1;
    expect_out("zero", 1'b1, 32'h00000000, 32'h00000000 ^ K);

    // branch seen with fs empty: delay slot first, then target
    tick(); reset = 1'b0; #1;
    tick(); reset = 1'b1; #1;
    tick(); bus.br_bus = {1'b1, 32'hBFC00300}; #1;
    expect_req("empty_br", 1'b1, 32'hBFC00000);
    tick(); bus.br_bus = '0; #1;
    expect_out("empty_ds", 1'b1, 32'hBFC00000, 32'hBFC00000 ^ K);
    expect_req("empty_tgt", 1'b1, 32'hBFC00300);
    tick(); #1;
    expect_out("empty_tgt", 1'b1, 32'hBFC00300, 32'hBFC00300 ^ K);
    expect_req("empty_clr", 1'b1, 32'hBFC00304);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline.
- Generates the next PC (pre-IF) and issues requests to a synchronous instruction SRAM with 1-cycle read latency.
- Holds the fetched {pc, inst} and delivers it to decode over the valid/allowin handshake as fs_to_ds_bus.
- Consumes br_bus from decode and redirects fetch after the delay slot, which follows MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'hBFC00000, address of the first fetched instruction.
- XLEN, 32, PC/instruction width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- ds_allowin  input  1  decode can accept a new bus this cycle.
- br_bus  input  33  {br_taken[32], br_target[31:0]} from decode; br_taken is already gated by decode-valid.
- fs_to_ds_valid  output  1  fs_to_ds_bus is valid.
- fs_to_ds_bus  output  64  {fs_pc[63:32], fs_inst[31:0]}.
- inst_sram_en  output  1  read request strobe.
- inst_sram_we  output  4  byte write enables, tied 4'b0.
- inst_sram_addr  output  32  read address (= nextpc).
- inst_sram_wdata  output  32  tied 0.
- inst_sram_rdata  input  32  read data, valid the cycle after an accepted request.

Behaviour:
- Reset (async assert, sync release), all registers clear:
  - preif_valid=0, fs_valid=0, fs_pc=RESET_PC-4.
  - data_fresh=0, buf_valid=0, inst_buf=0.
  - br_pend=0, br_pend_target=0.
- Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0.
- Pre-IF start: preif_valid becomes 1 on the first rising edge after release and stays 1. The first request therefore issues one cycle after release, at addr RESET_PC.
- Handshake:
  - fs_ready_go=1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
  - fs_to_ds_valid = fs_valid & fs_ready_go.
- nextpc priority:
  1. br_taken & fs_valid → br_target.
  2. br_pend & fs_valid → br_pend_target.
  3. Otherwise → fs_pc + 4, with 32-bit wrap (0xFFFFFFFC → 0x0).
- Request: inst_sram_en = preif_valid & fs_allowin; inst_sram_addr = nextpc.
- Request accept (inst_sram_en=1): fs_valid<=1, fs_pc<=nextpc, data_fresh<=1, buf_valid<=0.
- No request: data_fresh<=0. fs_valid clears only when the bus is consumed (fs_to_ds_valid & ds_allowin) with no new request; cannot occur after start-up, but required.
- Instruction source: fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- Stall capture: if data_fresh & fs_valid & ~ds_allowin, then inst_buf<=inst_sram_rdata and buf_valid<=1. Buffered data is held until the bus is consumed. SRAM rdata is not relied upon after its fresh cycle.
- Branch, delay slot:
  - br_taken is asserted while the delay slot sits in fs.
  - The target is fetched as the instruction after the delay slot.
  - The delay slot is never squashed.
- Branch while stalled: if br_taken & fs_valid & ~inst_sram_en, then br_pend<=1 and br_pend_target<=br_target.
- Branch with fs empty: if br_taken & ~fs_valid, then latch br_pend/br_pend_target and fetch fs_pc+4 (the delay slot) first. The target follows on the next accepted request.
- br_pend clears on the first accepted request that uses rule 1 or 2.
- Simultaneous br_taken and br_pend: live br_target wins and br_pend clears.
- Reset mid-operation: all state returns to reset values immediately. Any outstanding SRAM read is ignored because data_fresh=0.
- Latency: request at cycle N → fs_to_ds_valid with matching pc/inst at cycle N+1 → consumed on the first cycle with ds_allowin=1.

Test Plan:
- Reset release: reset 0→1.
  - Cycle 0: inst_sram_en=0, fs_to_ds_valid=0.
  - Cycle 1: en=1, addr=0xBFC00000.
  - Cycle 2: fs_to_ds_bus={0xBFC00000, rdata}, en=1, addr=0xBFC00004.
- Sequential stream: ds_allowin=1, rdata=addr^0x5A5A5A5A.
  - fs_pc sequence 0xBFC00000, …04, …08, …0C.
  - Each fs_inst equals pc^0x5A5A5A5A.
  - No gaps.
- Decode stall: ds_allowin=0 for 3 cycles while fs holds pc 0xBFC00008; SRAM rdata driven to 0xDEADBEEF after the fresh cycle.
  - inst_sram_en=0 during the stall.
  - fs_to_ds_bus stays {0xBFC00008, original inst} throughout.
  - On release, next addr is 0xBFC0000C.
- Taken branch: br_bus={1, 0xBFC00100} for one cycle while fs holds delay slot 0xBFC00010, ds_allowin=1.
  - Request addr 0xBFC00100.
  - Delivered pcs: …10, then …100, …104.
- Branch during stall: br_taken with target 0xBFC00200 asserted for one cycle while ds_allowin=0.
  - br_pend latched.
  - After the stall, first addr is 0xBFC00200 and br_pend clears.
- Reset mid-stream: assert reset in the cycle after a request.
  - Outputs drop immediately.
  - After release, fetch restarts at 0xBFC00000.
  - The stale rdata is never delivered.
